// File: rtl/ahb_sram_slave.sv
// Pipelined AHB-style bus slave in front of a 1-cycle-latency synchronous SRAM macro.
// Decodes its region, checks size/alignment, builds byte enables and inserts wait states.
module ahb_sram_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [1:0]            trf_i,
  input  logic [2:0]            size_i,
  input  logic [31:0]           dir_i,
  input  logic                  write_i,
  input  logic [31:0]           datw_i,
  output logic [31:0]           readdat_o,
  output logic                  rdy_o,
  output logic                  resp_o,
  output logic                  sram_req_o,
  output logic                  sram_we_o,
  output logic [3:0]            sram_be_o,
  output logic [ADDR_WIDTH-1:0] sram_addr_o,
  output logic [31:0]           sram_wdata_o,
  input  logic [31:0]           sram_rdata_i
);

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned TAG_LSB = ADDR_WIDTH + 2;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_WR, S_RD_REQ, S_RD_DONE, S_ERR1, S_ERR2
  } state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [3:0]            be_q;
  logic                  write_q;
  logic [CNT_W-1:0]      cnt_q;

  logic                  accept;
  logic                  size_err;
  logic                  region_err;
  logic                  xfer_err;
  logic                  wait_done;
  logic                  issue;
  logic [3:0]            be_c;
  logic                  issue_write;
  logic [3:0]            issue_be;
  logic [ADDR_WIDTH-1:0] issue_addr;
  logic                  unused;

  assign unused = trf_i[0];

  // Byte-lane decode and size/alignment legality of the live address phase
  always_comb begin
    be_c     = 4'b0000;
    size_err = 1'b0;
    case (size_i)
      3'd0: be_c = 4'b0001 << dir_i[1:0];
      3'd1: begin
        be_c     = dir_i[1] ? 4'b1100 : 4'b0011;
        size_err = dir_i[0];
      end
      3'd2: begin
        be_c     = 4'b1111;
        size_err = |dir_i[1:0];
      end
      default: size_err = 1'b1;
    endcase
  end

  assign accept     = rdy_o & trf_i[1];
  assign region_err = dir_i[31:TAG_LSB] != BASE_ADDR[31:TAG_LSB];
  assign xfer_err   = size_err | region_err;
  assign wait_done  = (state_q == S_WAIT) && (cnt_q == CNT_W'(1));

  // After wait states the latched request is replayed; otherwise the live address phase goes straight out
  assign issue       = wait_done | (accept & ~xfer_err & (WAIT_STATES == 0));
  assign issue_write = wait_done ? write_q : write_i;
  assign issue_be    = wait_done ? be_q    : be_c;
  assign issue_addr  = wait_done ? addr_q  : dir_i[ADDR_WIDTH+1:2];

  assign readdat_o    = (state_q == S_RD_DONE) ? sram_rdata_i : 32'h0;
  assign sram_wdata_o = datw_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      rdy_o       <= 1'b1;
      resp_o      <= 1'b0;
      sram_req_o  <= 1'b0;
      sram_we_o   <= 1'b0;
      sram_be_o   <= 4'b0000;
      sram_addr_o <= '0;
      addr_q      <= '0;
      be_q        <= 4'b0000;
      write_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= S_IDLE;
      rdy_o       <= 1'b1;
      resp_o      <= 1'b0;
      sram_req_o  <= 1'b0;
      sram_we_o   <= 1'b0;
      sram_be_o   <= 4'b0000;
      sram_addr_o <= '0;
      if (state_q == S_WAIT) cnt_q <= cnt_q - CNT_W'(1);
      if (accept) begin
        addr_q  <= dir_i[ADDR_WIDTH+1:2];
        be_q    <= be_c;
        write_q <= write_i;
      end
      if (issue) begin
        sram_req_o  <= 1'b1;
        sram_we_o   <= issue_write;
        sram_be_o   <= issue_be;
        sram_addr_o <= issue_addr;
        state_q     <= issue_write ? S_WR : S_RD_REQ;
        rdy_o       <= issue_write;
      end else if (accept) begin
        rdy_o <= 1'b0;
        if (xfer_err) begin
          state_q <= S_ERR1;
          resp_o  <= 1'b1;
        end else begin
          state_q <= S_WAIT;
          cnt_q   <= CNT_W'(WAIT_STATES);
        end
      end else begin
        case (state_q)
          S_WAIT: begin
            state_q <= S_WAIT;
            rdy_o   <= 1'b0;
          end
          S_RD_REQ: state_q <= S_RD_DONE;
          S_ERR1: begin
            state_q <= S_ERR2;
            resp_o  <= 1'b1;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule
